// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network classifier: controller
// states, default widths/timing, and the LIF neuron constants used by the datapath.
package snn_pkg;

    localparam int unsigned SNN_PIXEL_W       = 8;
    localparam int unsigned SNN_DIGIT_W       = 4;
    localparam int unsigned SNN_NUM_STEPS     = 32;
    localparam int unsigned SNN_SETTLE_CYCLES = 2;
    localparam int unsigned SNN_CNT_W         = 8;

    // LIF neuron constants shared with the network datapath
    localparam int unsigned LIF_V_W        = 10;
    localparam int unsigned LIF_V_THRESH   = 64;
    localparam int unsigned LIF_LEAK_SHIFT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_DONE
    } snn_state_e;

endpackage

// File: rtl/snn_step_counter.sv
// 8-bit timestep counter shared by the RUN and SETTLE phases; flags a match
// against the caller-supplied terminal value.
module snn_step_counter
    import snn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 en,
    input  logic [SNN_CNT_W-1:0] term,
    output logic [SNN_CNT_W-1:0] count,
    output logic                 at_term_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + SNN_CNT_W'(1);
        end
    end

    assign at_term_c = (count == term);

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference sequencer: clears the network, drives the captured sample for a
// fixed number of timesteps, waits for the readout to settle, then reports the digit.
module snn_inference_ctrl
    import snn_pkg::*;
#(
    parameter int unsigned NUM_STEPS     = SNN_NUM_STEPS,
    parameter int unsigned SETTLE_CYCLES = SNN_SETTLE_CYCLES,
    parameter int unsigned PIXEL_W       = SNN_PIXEL_W,
    parameter int unsigned DIGIT_W       = SNN_DIGIT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [PIXEL_W-1:0] sample_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               net_clear_o,
    output logic               net_en_o,
    output logic               busy_o,
    output logic [7:0]         step_o,
    output logic               valid_o,
    output logic [DIGIT_W-1:0] digit_o
);

    localparam int unsigned CNT_W = SNN_CNT_W;
    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    snn_state_e         state_q, state_d;
    logic [PIXEL_W-1:0] pixel_q;
    logic [DIGIT_W-1:0] digit_q;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_at_term;
    logic               cnt_clear, cnt_en;
    logic [CNT_W-1:0]   cnt_term;
    logic               pix_load, pix_clear, digit_load;

    snn_step_counter u_step_counter (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear     (cnt_clear),
        .en        (cnt_en),
        .term      (cnt_term),
        .count     (cnt),
        .at_term_c (cnt_at_term)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; abort overrides every active state.
    always_comb begin
        state_d    = state_q;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        cnt_term   = RUN_LAST;
        pix_load   = 1'b0;
        pix_clear  = 1'b0;
        digit_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clear = 1'b1;
                if (start_i && !abort_i) begin
                    pix_load = 1'b1;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_clear = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_at_term) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_SETTLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_term = SETTLE_LAST;
                if (cnt_at_term) begin
                    cnt_clear  = 1'b1;
                    digit_load = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            pix_clear  = 1'b1;
            digit_load = 1'b0;
            cnt_clear  = 1'b1;
            cnt_en     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pixel_q <= '0;
        end else if (pix_clear) begin
            pixel_q <= '0;
        end else if (pix_load) begin
            pixel_q <= sample_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else if (digit_load) begin
            digit_q <= digit_i;
        end
    end

    // Moore decode of the registered state
    assign busy_o      = (state_q != ST_IDLE);
    assign net_clear_o = (state_q == ST_CLEAR);
    assign net_en_o    = (state_q == ST_RUN);
    assign valid_o     = (state_q == ST_DONE);
    assign pixel_o     = (state_q == ST_RUN) ? pixel_q : '0;
    assign step_o      = (state_q == ST_RUN) ? cnt : 8'd0;
    assign digit_o     = digit_q;

endmodule
